sec_countdown: RTL

//  Seconds stage of the bomb countdown timer; sits directly upstream of the minute counter.

---
 rtl/sec_countdown.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sec_countdown.sv
// Seconds stage of the countdown timer: 1 Hz prescaler plus a BCD 59..00 down-counter with run/pause/stop control.
// Optional seven-segment outputs hex_tens/hex_units are built when SEVSEG_DISPLAY_EN is defined.
module sec_countdown #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       min_tick,
  output logic       running
`ifdef SEVSEG_DISPLAY_EN
  ,
  output logic [6:0] hex_tens,
  output logic [6:0] hex_units
`endif
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [3:0]    tens_reg, tens_next;
  logic [3:0]    units_reg, units_next;
  logic          tick_reg, tick_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      tens_reg  <= 4'd0;
      units_reg <= 4'd0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      tens_reg  <= tens_next;
      units_reg <= units_next;
      tick_reg  <= tick_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    tens_next  = tens_reg;
    units_next = units_reg;
    tick_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        presc_next = '0;
        tens_next  = 4'd0;
        units_next = 4'd0;
        if (stop)       state_next = DONE;
        else if (start) state_next = RUN;
      end
      RUN: begin
        // stop/pause win over the terminal count, so the prescaler is simply held
        if (stop) begin
          state_next = DONE;
        end else if (pause) begin
          state_next = PAUSE;
        end else if (presc_reg == TC) begin
          presc_next = '0;
          if (units_reg != 4'd0) begin
            units_next = units_reg - 4'd1;
          end else if (tens_reg != 4'd0) begin
            tens_next  = tens_reg - 4'd1;
            units_next = 4'd9;
          end else begin
            tens_next  = 4'd5;
            units_next = 4'd9;
            tick_next  = 1'b1;
          end
        end else begin
          presc_next = presc_reg + PW'(1);
        end
      end
      PAUSE: begin
        if (stop)        state_next = DONE;
        else if (!pause) state_next = RUN;
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
        presc_next = '0;
        tens_next  = 4'd0;
        units_next = 4'd0;
      end
    endcase
  end

  assign sec_tens  = tens_reg;
  assign sec_units = units_reg;
  assign min_tick  = tick_reg;
  assign running   = (state_reg == RUN);

`ifdef SEVSEG_DISPLAY_EN
  // Active-low segments ordered {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign hex_tens  = seg7(tens_reg);
  assign hex_units = seg7(units_reg);
`endif

endmodule
